pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline stage register: next generation of the fixed ID/EX latch.
//  - Carries a control field and a data field with valid/ready flow control.
//  - Optional skid buffer, so in_ready carries no combinational path from out_ready.
//  - Flush inserts a bubble: both fields are zeroed.
//  - Saturating stall and flush counters for performance debug.
//  - One instance per pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
// PARAMETERS
//  CTRL_W  9    control bits; forced to 0 whenever the entry is invalid or flushed
//  DATA_W  111  payload bits (ID/EX: 2x32 regs, 32 imm, 3x5 reg ids)
//  SKID    1    1 = two-entry skid buffer, registered in_ready; 0 = single entry
//  CNT_W   16   width of each perf counter
// PORTS
//  clk        in   1       clock, rising edge
//  clr        in   1       synchronous active-high reset
//  flush      in   1       sync flush: discard all held entries at this edge
//  in_valid   in   1       upstream entry valid
//  in_ready   out  1       stage accepts input this cycle
//  in_ctrl    in   CTRL_W  upstream control field
//  in_data    in   DATA_W  upstream data field
//  out_valid  out  1       output entry valid
//  out_ready  in   1       downstream accepts this cycle (0 = stall)
//  out_ctrl   out  CTRL_W  output control field; all-zero when out_valid=0
//  out_data   out  DATA_W  output data field
//  stall_cnt  out  CNT_W   cycles with out_valid & ~out_ready; saturates
//  flush_cnt  out  CNT_W   flushes that discarded >=1 valid entry; saturates
// BEHAVIOUR
//  - Reset: clr=1 at posedge zeroes every output, the skid entry and both counters.
//    clr has priority over flush and over any handshake.
//  - Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Latency and throughput: empty stage gives 1 cycle in->out; 1 entry/cycle sustained.
//  - SKID=1: main register (M) drives the outputs; skid register (S) sits behind it.
//    in_ready = ~S.valid & ~flush, so it is registered apart from the flush gate.
//    out_fire & S.valid: M<=S, S<=empty.
//    out_fire & ~S.valid: M<=in if in_fire, else M<=empty.
//    No out_fire, M empty: M<=in if in_fire.
//    No out_fire, M valid, in_fire: S<=in.
//    Order is preserved; S never fills while M is empty.
//  - SKID=0: no S. in_ready = (~out_valid | out_ready) & ~flush.
//    M<=in on in_fire; M<=empty on out_fire & ~in_fire.
//  - Flush: M and S are invalidated, ctrl and data zeroed. in_ready=0 in that cycle,
//    so no entry is accepted and none is lost. Flush takes precedence over out_fire.
//    A flush on an empty stage is legal and leaves the counters unchanged.
//  - Invalid entries always hold ctrl=0 and data=0, so a consumer that ignores valid
//    sees a NOP. This matches the legacy clear semantics.
//  - Held output: out_valid & ~out_ready keeps out_ctrl and out_data stable.
//  - in_valid=0 with in_ready=1 changes no state.
//  - stall_cnt: +1 per cycle with out_valid & ~out_ready & ~flush; holds at 2^CNT_W-1.
//  - flush_cnt: +1 per flush with M.valid | S.valid; holds at 2^CNT_W-1.
//  - Simultaneous clr and flush: reset result; counters read 0.
// STRUCTURE
//  - Package pipe_pkg holds the per-boundary constants:
//    IDEX_CTRL_W, IDEX_DATA_W; bit offsets for RegWrite, MemtoReg, MemWrite,
//    ALUControl[3:0], ALUSrc, RegDst; field offsets for rs, rt, rd, imm, reg1, reg2.
//  - Sub-module sat_counter (params W; ports clk, clr, inc, q) is used twice.
//  - The skid path is generate-selected on SKID; no latches, one always block per register.
// TESTING
//  1. Reset: clr=1 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, counters 0, in_ready=1.
//  2. Stream: in_data=1,2,3 back-to-back, out_ready=1 -> out_data 1,2,3 on cycles 1,2,3;
//     in_ready stays 1.
//  3. Stall (SKID=1): send 0xA,0xB; drop out_ready for 3 cycles ->
//     out_data=0xA held, in_ready=0 after 0xB; stall_cnt=3; release gives 0xA then 0xB.
//  4. Flush with M and S full, in_valid=1 in same cycle -> next cycle out_valid=0,
//     out_ctrl=0, out_data=0; input not taken; flush_cnt=1; empty-stage flush leaves it 1.
//  5. Saturation with CNT_W=4: hold stall 20 cycles -> stall_cnt=15 and stays 15.
//  6. SKID=0 regression: out_ready=0 with out_valid=1 -> in_ready=0 the same cycle;
//     random valid/ready soak against a FIFO scoreboard shows no loss, duplication or reorder.

Source files
------------

// File: rtl/pipe_pkg.sv
// Pipeline boundary constants shared by every stage register instance.
// Holds ID/EX field widths, control bit offsets and data field offsets.
package pipe_pkg;

    localparam int IDEX_CTRL_W = 9;
    localparam int IDEX_DATA_W = 111;

    // ID/EX control field bit offsets
    localparam int CTRL_REG_DST_BIT    = 0;
    localparam int CTRL_ALU_SRC_BIT    = 1;
    localparam int CTRL_ALU_CTRL_LSB   = 2;
    localparam int CTRL_ALU_CTRL_W     = 4;
    localparam int CTRL_MEM_WRITE_BIT  = 6;
    localparam int CTRL_MEM_TO_REG_BIT = 7;
    localparam int CTRL_REG_WRITE_BIT  = 8;

    // ID/EX data field offsets
    localparam int WORD_W   = 32;
    localparam int REG_ID_W = 5;
    localparam int RD_LSB   = 0;
    localparam int RT_LSB   = 5;
    localparam int RS_LSB   = 10;
    localparam int IMM_LSB  = 15;
    localparam int REG2_LSB = 47;
    localparam int REG1_LSB = 79;

    // Packed views whose bit positions line up with the offsets above
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic       reg_dst;
    } idex_ctrl_t;

    typedef struct packed {
        logic [WORD_W-1:0]   reg1;
        logic [WORD_W-1:0]   reg2;
        logic [WORD_W-1:0]   imm;
        logic [REG_ID_W-1:0] rs;
        logic [REG_ID_W-1:0] rt;
        logic [REG_ID_W-1:0] rd;
    } idex_data_t;

    typedef enum logic [1:0] {
        BND_IF_ID,
        BND_ID_EX,
        BND_EX_MEM,
        BND_MEM_WB
    } boundary_e;

    function automatic idex_ctrl_t idex_ctrl_unpack(
        input logic [IDEX_CTRL_W-1:0] bits
    );
        return idex_ctrl_t'(bits);
    endfunction

    function automatic idex_data_t idex_data_unpack(
        input logic [IDEX_DATA_W-1:0] bits
    );
        return idex_data_t'(bits);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for stage performance statistics.
// Ports: clk, clr (sync reset), inc (count enable), q (count, sticks at max).
module sat_counter
    import pipe_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready flow control, optional skid entry,
// flush-to-bubble and saturating stall/flush counters.
// Ports: clk, clr (sync reset), flush; in_valid/in_ready/in_ctrl/in_data
// upstream; out_valid/out_ready/out_ctrl/out_data downstream; stall_cnt,
// flush_cnt perf counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              m_valid_q;
    logic              m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q;
    logic [CTRL_W-1:0] m_ctrl_d;
    logic [DATA_W-1:0] m_data_q;
    logic [DATA_W-1:0] m_data_d;

    logic s_valid;
    logic in_fire;
    logic out_fire;
    logic stall_inc;
    logic flush_inc;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_valid_q & out_ready;

    if (SKID != 0) begin : g_skid

        logic              s_valid_q;
        logic              s_valid_d;
        logic [CTRL_W-1:0] s_ctrl_q;
        logic [CTRL_W-1:0] s_ctrl_d;
        logic [DATA_W-1:0] s_data_q;
        logic [DATA_W-1:0] s_data_d;

        // Only the flush gate is combinational; the rest comes from a flop.
        assign in_ready = ~s_valid_q & ~flush;
        assign s_valid  = s_valid_q;

        always_comb begin
            m_valid_d = m_valid_q;
            m_ctrl_d  = m_ctrl_q;
            m_data_d  = m_data_q;
            s_valid_d = s_valid_q;
            s_ctrl_d  = s_ctrl_q;
            s_data_d  = s_data_q;
            if (flush) begin
                m_valid_d = 1'b0;
                m_ctrl_d  = '0;
                m_data_d  = '0;
                s_valid_d = 1'b0;
                s_ctrl_d  = '0;
                s_data_d  = '0;
            end else if (out_fire) begin
                if (s_valid_q) begin
                    // in_ready was low, so no new entry competes here
                    m_valid_d = 1'b1;
                    m_ctrl_d  = s_ctrl_q;
                    m_data_d  = s_data_q;
                    s_valid_d = 1'b0;
                    s_ctrl_d  = '0;
                    s_data_d  = '0;
                end else if (in_fire) begin
                    m_valid_d = 1'b1;
                    m_ctrl_d  = in_ctrl;
                    m_data_d  = in_data;
                end else begin
                    m_valid_d = 1'b0;
                    m_ctrl_d  = '0;
                    m_data_d  = '0;
                end
            end else if (!m_valid_q) begin
                if (in_fire) begin
                    m_valid_d = 1'b1;
                    m_ctrl_d  = in_ctrl;
                    m_data_d  = in_data;
                end
            end else if (in_fire) begin
                // M is held by a stall: park the newcomer behind it
                s_valid_d = 1'b1;
                s_ctrl_d  = in_ctrl;
                s_data_d  = in_data;
            end
        end

        always_ff @(posedge clk) begin
            if (clr) begin
                s_valid_q <= 1'b0;
                s_ctrl_q  <= '0;
                s_data_q  <= '0;
            end else begin
                s_valid_q <= s_valid_d;
                s_ctrl_q  <= s_ctrl_d;
                s_data_q  <= s_data_d;
            end
        end

    end else begin : g_flat

        assign in_ready = (~m_valid_q | out_ready) & ~flush;
        assign s_valid  = 1'b0;

        always_comb begin
            m_valid_d = m_valid_q;
            m_ctrl_d  = m_ctrl_q;
            m_data_d  = m_data_q;
            if (flush) begin
                m_valid_d = 1'b0;
                m_ctrl_d  = '0;
                m_data_d  = '0;
            end else if (in_fire) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = in_ctrl;
                m_data_d  = in_data;
            end else if (out_fire) begin
                m_valid_d = 1'b0;
                m_ctrl_d  = '0;
                m_data_d  = '0;
            end
        end

    end

    always_ff @(posedge clk) begin
        if (clr) begin
            m_valid_q <= 1'b0;
            m_ctrl_q  <= '0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_ctrl_q  <= m_ctrl_d;
            m_data_q  <= m_data_d;
        end
    end

    assign out_valid = m_valid_q;
    assign out_ctrl  = m_ctrl_q;
    assign out_data  = m_data_q;

    // A flushed cycle is not a stall: the held entry is being discarded.
    assign stall_inc = m_valid_q & ~out_ready & ~flush;
    assign flush_inc = flush & (m_valid_q | s_valid);

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .clr (clr),
        .inc (stall_inc),
        .q   (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .clr (clr),
        .inc (flush_inc),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: SKID=1 (4-bit counters) and SKID=0
// instances share stimulus; each is checked against a FIFO reference model.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CW = IDEX_CTRL_W;
    localparam int DW = IDEX_DATA_W;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } item_t;

    logic          clk = 1'b0;
    logic          clr;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          i1_ready, o1_valid;
    logic [CW-1:0] o1_ctrl;
    logic [DW-1:0] o1_data;
    logic [3:0]    st1, fl1;

    logic          i0_ready, o0_valid;
    logic [CW-1:0] o0_ctrl;
    logic [DW-1:0] o0_data;
    logic [15:0]   st0, fl0;

    item_t q1[$];
    item_t q0[$];
    int    tests = 0;
    int    fails = 0;
    int    e_st1 = 0, e_fl1 = 0, e_st0 = 0, e_fl0 = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1), .CNT_W(4)) dut1 (
        .clk(clk), .clr(clr), .flush(flush),
        .in_valid(in_valid), .in_ready(i1_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(o1_valid), .out_ready(out_ready),
        .out_ctrl(o1_ctrl), .out_data(o1_data),
        .stall_cnt(st1), .flush_cnt(fl1)
    );

    pipe_stage_reg #(.SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .clr(clr), .flush(flush),
        .in_valid(in_valid), .in_ready(i0_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(o0_valid), .out_ready(out_ready),
        .out_ctrl(o0_ctrl), .out_data(o0_data),
        .stall_cnt(st0), .flush_cnt(fl0)
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor for the skid instance: up to two entries may be in flight.
    always @(negedge clk) begin
        if (clr) begin
            q1.delete();
            e_st1 = 0;
            e_fl1 = 0;
        end else begin
            chk("s1_out_valid", 128'(o1_valid), 128'(q1.size() != 0));
            chk("s1_in_ready", 128'(i1_ready),
                128'((q1.size() < 2) && !flush));
            if (q1.size() != 0) begin
                chk("s1_out_ctrl", 128'(o1_ctrl), 128'(q1[0].c));
                chk("s1_out_data", 128'(o1_data), 128'(q1[0].d));
            end else begin
                chk("s1_bubble_ctrl", 128'(o1_ctrl), 128'(0));
                chk("s1_bubble_data", 128'(o1_data), 128'(0));
            end
            chk("s1_stall_cnt", 128'(st1), 128'(e_st1));
            chk("s1_flush_cnt", 128'(fl1), 128'(e_fl1));
            if (q1.size() != 0 && !out_ready && !flush && e_st1 < 15)
                e_st1++;
            if (flush && q1.size() != 0 && e_fl1 < 15)
                e_fl1++;
            if (q1.size() != 0 && out_ready)
                void'(q1.pop_front());
            if (flush)
                q1.delete();
        end
    end

    // Monitor for the single-entry instance.
    always @(negedge clk) begin
        if (clr) begin
            q0.delete();
            e_st0 = 0;
            e_fl0 = 0;
        end else begin
            chk("s0_out_valid", 128'(o0_valid), 128'(q0.size() != 0));
            chk("s0_in_ready", 128'(i0_ready),
                128'((q0.size() == 0 || out_ready) && !flush));
            if (q0.size() != 0) begin
                chk("s0_out_ctrl", 128'(o0_ctrl), 128'(q0[0].c));
                chk("s0_out_data", 128'(o0_data), 128'(q0[0].d));
            end else begin
                chk("s0_bubble_ctrl", 128'(o0_ctrl), 128'(0));
                chk("s0_bubble_data", 128'(o0_data), 128'(0));
            end
            chk("s0_stall_cnt", 128'(st0), 128'(e_st0));
            chk("s0_flush_cnt", 128'(fl0), 128'(e_fl0));
            if (q0.size() != 0 && !out_ready && !flush && e_st0 < 65535)
                e_st0++;
            if (flush && q0.size() != 0 && e_fl0 < 65535)
                e_fl0++;
            if (q0.size() != 0 && out_ready)
                void'(q0.pop_front());
            if (flush)
                q0.delete();
        end
    end

    // Drive one cycle; entries each instance accepts go to its scoreboard.
    task automatic step(input logic v, input logic [CW-1:0] c,
                        input logic [DW-1:0] d, input logic ordy,
                        input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        #1;
        if (!clr && in_valid && i1_ready)
            q1.push_back(item_t'{c: c, d: d});
        if (!clr && in_valid && i0_ready)
            q0.push_back(item_t'{c: c, d: d});
        @(posedge clk);
        #1;
    endtask

    logic [CW-1:0]  rc;
    logic [127:0]   rw;
    logic [DW-1:0]  rd;

    initial begin
        clr       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset with traffic and a flush pending
        step(1'b1, CW'(9'h1FF), DW'(7), 1'b1, 1'b0);
        step(1'b1, CW'(9'h1FF), DW'(7), 1'b1, 1'b1);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 128'(o1_valid), 128'(0));
        chk("rst_out_ctrl", 128'(o1_ctrl), 128'(0));
        chk("rst_out_data", 128'(o1_data), 128'(0));
        chk("rst_stall_cnt", 128'(st1), 128'(0));
        chk("rst_flush_cnt", 128'(fl1), 128'(0));
        chk("rst_in_ready", 128'(i1_ready), 128'(1));
        chk("rst0_out_valid", 128'(o0_valid), 128'(0));
        clr = 1'b0;

        // Back-to-back stream, one-cycle latency
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, CW'(k), DW'(k), 1'b1, 1'b0);
            chk("stream_data", 128'(o1_data), 128'(k));
            chk("stream_valid", 128'(o1_valid), 128'(1));
            chk("stream_ready", 128'(i1_ready), 128'(1));
            chk("stream0_data", 128'(o0_data), 128'(k));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Stall with skid fill
        step(1'b1, CW'(9'h0A), DW'(32'hA), 1'b0, 1'b0);
        step(1'b1, CW'(9'h0B), DW'(32'hB), 1'b0, 1'b0);
        chk("stall_in_ready", 128'(i1_ready), 128'(0));
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("stall_cnt3", 128'(st1), 128'(3));
        chk("stall_held", 128'(o1_data), 128'(32'hA));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("release_b", 128'(o1_data), 128'(32'hB));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("release_empty", 128'(o1_valid), 128'(0));

        // Flush with both entries full and an input offered
        step(1'b1, CW'(9'h0C), DW'(32'hC), 1'b0, 1'b0);
        step(1'b1, CW'(9'h0D), DW'(32'hD), 1'b0, 1'b0);
        step(1'b1, CW'(9'h0E), DW'(32'hE), 1'b0, 1'b1);
        chk("flush_valid", 128'(o1_valid), 128'(0));
        chk("flush_ctrl", 128'(o1_ctrl), 128'(0));
        chk("flush_data", 128'(o1_data), 128'(0));
        chk("flush_cnt1", 128'(fl1), 128'(1));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("flush_not_taken", 128'(o1_valid), 128'(0));
        step(1'b0, '0, '0, 1'b1, 1'b1);
        chk("flush_empty", 128'(fl1), 128'(1));

        // Stall counter saturation
        step(1'b1, CW'(9'h0F), DW'(32'hF), 1'b0, 1'b0);
        for (int k = 0; k < 20; k++)
            step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("sat_stall", 128'(st1), 128'(15));
        chk("flat_ready_low", 128'(i0_ready), 128'(0));
        chk("flat_valid_held", 128'(o0_valid), 128'(1));
        for (int k = 0; k < 3; k++)
            step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("sat_stall_hold", 128'(st1), 128'(15));
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Random soak
        for (int k = 0; k < 1500; k++) begin
            rc = CW'($urandom);
            rw = {$urandom, $urandom, $urandom, $urandom};
            rd = rw[DW-1:0];
            step(1'(($urandom % 4) != 0), rc, rd,
                 1'(($urandom % 4) != 0), 1'(($urandom % 50) == 0));
        end
        for (int k = 0; k < 4; k++)
            step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drain1", 128'(q1.size()), 128'(0));
        chk("drain0", 128'(q0.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
